pocket_i2s_tx: RTL and testbench
================================

# pocket_i2s_tx

Parametrised I2S / left-justified audio transmitter for the Pocket audio path. It generates its own serial clock (`audio_sclk`) and word clock (`audio_lrck`) from one master audio clock. Stereo samples are buffered in a small FIFO with a valid/ready handshake and serialised MSB-first into a configurable slot width. On FIFO underrun it repeats the last frame and flags the condition.

## Interface
Parameters:
- `SAMPLE_WIDTH`, 16: bits per channel sample, 1..`SLOT_WIDTH`
- `SLOT_WIDTH`, 32: sclk periods per channel slot, 16..32
- `MCLK_DIV`, 4: `audio_mclk` cycles per `audio_sclk` period; even, >=2
- `FIFO_DEPTH`, 4: stereo frames buffered; power of two, >=2
- `FORMAT`, `FMT_I2S`: `FMT_I2S` (MSB one sclk after lrck edge) or `FMT_LJ` (MSB coincident with lrck edge)

Ports:
- `audio_mclk` in 1: master audio clock; only clock
- `reset` in 1: synchronous, active-high reset
- `audio_l` in `SAMPLE_WIDTH`: left sample, two's complement
- `audio_r` in `SAMPLE_WIDTH`: right sample
- `audio_valid` in 1: sample pair present
- `audio_ready` out 1: FIFO can accept; `level < FIFO_DEPTH`
- `audio_sclk` out 1: serial clock, registered
- `audio_lrck` out 1: 0 = left slot, 1 = right slot, registered
- `audio_dac` out 1: serial data, registered
- `underrun` out 1: one-cycle pulse, frame start with empty FIFO
- `fifo_level` out `$clog2(FIFO_DEPTH+1)`: frames held

## Operation
- Divider `div_cnt` counts 0..`MCLK_DIV-1` and wraps.
- `audio_sclk` is registered as `next_div_cnt >= MCLK_DIV/2`: low in the first half of each period, high in the second.
- Fall tick: the cycle where `div_cnt == MCLK_DIV-1`. All lrck, data and frame updates register on a fall tick, so they change together with the sclk falling edge.
- `bit_cnt` runs 0..`2*SLOT_WIDTH-1` and advances on each fall tick.
- `audio_lrck` is registered as `bit_cnt_next >= SLOT_WIDTH`.
- Frame start: the fall tick where `bit_cnt` wraps to 0.
  - FIFO not empty: pop the head into `cur_frame` {L, R}. The previous `cur_frame` moves to `prev_frame`.
  - FIFO empty: keep `cur_frame` (repeat) and pulse `underrun` in the same cycle.
- Slot bit `k` (0..`SLOT_WIDTH-1`) carries sample bit `SAMPLE_WIDTH-1-k` for `k < SAMPLE_WIDTH`, else 0.
- Data position:
  - `FMT_LJ`: `audio_dac` at position `bit_cnt` = slot bit `bit_cnt mod SLOT_WIDTH` of `cur_frame`.
  - `FMT_I2S`: position `bit_cnt` carries the `FMT_LJ` bit of position `bit_cnt-1`. Position 0 takes the last right-slot bit of `prev_frame`.
- FIFO handshake:
  - Push when `audio_valid && audio_ready`.
  - `audio_valid` while not ready is ignored. No stall and no data corruption.
  - Push and pop in the same cycle leave `fifo_level` unchanged.
  - A push into an empty FIFO on a frame-start cycle is not poppable until the next frame.

## Timing
- Reset values:
  - `div_cnt` 0; `bit_cnt` `2*SLOT_WIDTH-1`
  - `audio_sclk`, `audio_lrck`, `audio_dac`, `underrun` all 0
  - `fifo_level` 0, `audio_ready` 1
  - `cur_frame` and `prev_frame` 0
- First fall tick is cycle `MCLK_DIV-1` after reset deassert. This is the first frame start. The first sclk falling edge is at cycle `MCLK_DIV`.
- Frame period: `2*SLOT_WIDTH*MCLK_DIV` mclk cycles, constant and independent of the FIFO.
- Latency: a push into an empty FIFO reaches the first `audio_dac` bit at the next frame start (LJ), or one sclk period later (I2S).
- `fifo_level` and `audio_ready` update the cycle after a push or pop.
- Reset asserted mid-frame: all state returns to the reset values the next cycle. FIFO contents are discarded.

## Structure
- Package `pocket_audio_pkg` holds:
  - enum `fmt_e {FMT_I2S, FMT_LJ}`
  - localparam helpers for counter widths
- Sub-module `pocket_audio_fifo`: synchronous FIFO parametrised in data width (`2*SAMPLE_WIDTH`) and depth. Provides push, pop, level, full, empty.
- Clock divider, bit counter and serialiser live in the top module.

## Test plan
- Defaults, push L=16'h8001, R=16'h7FFE, then idle:
  - left slot `audio_dac` = 1,0..0,1 then 16 zeros; right slot 0,1..1,0 then zeros
  - I2S MSB appears one sclk after each lrck edge
  - no underrun at frame 0; `underrun` pulses at frame 1 with the same data repeated
- Reset release, no pushes:
  - `audio_sclk` period 4 cycles; lrck period 256 cycles
  - `audio_dac` stays 0; `underrun` pulses every 256 cycles
- Hold `audio_valid` high continuously:
  - `fifo_level` climbs to 4 and `audio_ready` drops
  - the 5th sample is not accepted until a pop
  - frames come out in push order with none lost or duplicated
- `FORMAT=FMT_LJ`, `SAMPLE_WIDTH=24`, `SLOT_WIDTH=24`, L=24'hABCDEF:
  - bits are MSB-first, aligned exactly with the lrck edge
  - no padding bits
- `MCLK_DIV=8`, push on the exact frame-start cycle with an empty FIFO:
  - `underrun` pulses
  - the sample plays at the following frame
- Assert reset mid-right-slot with 3 frames queued:
  - the next cycle shows every reset value and `fifo_level=0`
  - streaming restarts cleanly from frame start

Source files
------------

// File: rtl/pocket_audio_pkg.sv
// Shared types and width helpers for the Pocket audio transmit path.
// No logic; imported by the FIFO and the serialiser.
package pocket_audio_pkg;

  typedef enum logic {FMT_I2S, FMT_LJ} fmt_e;

  // Bits needed for a counter that runs 0..n-1 (never narrower than one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pocket_audio_fifo.sv
// Stereo frame FIFO: pop_dat is the registered head, visible combinationally; level updates one cycle after push/pop.
// No internal overflow/underflow guard: the caller pushes only when !full and pops only when !empty.
module pocket_audio_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_dat,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_dat,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic                           full,
  output logic                           empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage is not reset; resetting the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);

endmodule

// File: rtl/pocket_i2s_tx.sv
// I2S / left-justified transmitter: sclk and lrck divided from audio_mclk; frames popped at frame start, underrun repeats.
// A push reaches the wire at the next frame start (LJ) or one sclk later (I2S); audio_ready drops when the FIFO is full.
module pocket_i2s_tx
  import pocket_audio_pkg::*;
#(
  parameter int   SAMPLE_WIDTH = 16,
  parameter int   SLOT_WIDTH   = 32,
  parameter int   MCLK_DIV     = 4,
  parameter int   FIFO_DEPTH   = 4,
  parameter fmt_e FORMAT       = FMT_I2S
) (
  input  logic                              audio_mclk,
  input  logic                              reset,
  input  logic [SAMPLE_WIDTH-1:0]           audio_l,
  input  logic [SAMPLE_WIDTH-1:0]           audio_r,
  input  logic                              audio_valid,
  output logic                              audio_ready,
  output logic                              audio_sclk,
  output logic                              audio_lrck,
  output logic                              audio_dac,
  output logic                              underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int DW = cnt_w(MCLK_DIV);
  localparam int BW = cnt_w(2*SLOT_WIDTH);
  localparam int FW = 2*SAMPLE_WIDTH;

  localparam logic [DW-1:0] DIV_LAST = DW'(MCLK_DIV-1);
  localparam logic [DW-1:0] DIV_HALF = DW'(MCLK_DIV/2);
  localparam logic [BW-1:0] BIT_LAST = BW'(2*SLOT_WIDTH-1);
  localparam logic [BW-1:0] SLOT_LEN = BW'(SLOT_WIDTH);

  logic [DW-1:0] div_cnt, next_div_cnt;
  logic [BW-1:0] bit_cnt, bit_cnt_next;
  logic [FW-1:0] cur_frame, prev_frame, frame_next, prev_next, fifo_head;
  logic          fall_tick, frame_start, fifo_empty, fifo_full;
  logic          push, pop, dac_next;

  // Slot bit k is sample bit SAMPLE_WIDTH-1-k; the shift zero-pads past the sample.
  function automatic logic slot_bit(input logic [SAMPLE_WIDTH-1:0] s, input logic [BW-1:0] k);
    logic [SAMPLE_WIDTH-1:0] t;
    t = s << k;
    return t[SAMPLE_WIDTH-1];
  endfunction

  function automatic logic lj_bit(input logic [FW-1:0] f, input logic [BW-1:0] pos);
    if (pos < SLOT_LEN) return slot_bit(f[FW-1:SAMPLE_WIDTH], pos);
    return slot_bit(f[SAMPLE_WIDTH-1:0], pos - SLOT_LEN);
  endfunction

  always_comb begin
    fall_tick    = (div_cnt == DIV_LAST);
    next_div_cnt = fall_tick ? '0 : div_cnt + 1'b1;
    frame_start  = fall_tick && (bit_cnt == BIT_LAST);
    bit_cnt_next = bit_cnt;
    if (fall_tick) bit_cnt_next = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    pop          = frame_start && !fifo_empty && !reset;
    push         = audio_valid && !fifo_full && !reset;
    frame_next   = pop ? fifo_head : cur_frame;
    prev_next    = frame_start ? cur_frame : prev_frame;
    // I2S trails LJ by one position; position 0 carries the tail of the frame just played.
    if (FORMAT == FMT_LJ)
      dac_next = lj_bit(frame_next, bit_cnt_next);
    else if (bit_cnt_next == '0)
      dac_next = slot_bit(prev_next[SAMPLE_WIDTH-1:0], SLOT_LEN - 1'b1);
    else
      dac_next = lj_bit(frame_next, bit_cnt_next - 1'b1);
  end

  always_ff @(posedge audio_mclk) begin
    if (reset) begin
      div_cnt    <= '0;
      bit_cnt    <= BIT_LAST;
      audio_sclk <= 1'b0;
      audio_lrck <= 1'b0;
      audio_dac  <= 1'b0;
      cur_frame  <= '0;
      prev_frame <= '0;
    end else begin
      div_cnt    <= next_div_cnt;
      audio_sclk <= (next_div_cnt >= DIV_HALF);
      if (fall_tick) begin
        bit_cnt    <= bit_cnt_next;
        audio_lrck <= (bit_cnt_next >= SLOT_LEN);
        audio_dac  <= dac_next;
      end
      if (frame_start) begin
        prev_frame <= cur_frame;
        cur_frame  <= frame_next;
      end
    end
  end

  assign underrun    = frame_start && fifo_empty && !reset;
  assign audio_ready = !fifo_full;

  pocket_audio_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (audio_mclk),
    .reset    (reset),
    .push     (push),
    .push_dat ({audio_l, audio_r}),
    .pop      (pop),
    .pop_dat  (fifo_head),
    .level    (fifo_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_pocket_i2s_tx.sv
// Directed bench for pocket_i2s_tx: three instances (default I2S, LJ 24/24, MCLK_DIV=8).
// Serial frames are captured at sclk-high points and compared with hand-computed bit streams.
module tb_pocket_i2s_tx;
  import pocket_audio_pkg::*;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [63:0] i2s;
  } vec_t;

  logic        clk;
  logic [2:0]  rst;
  logic [2:0]  vld;
  logic [2:0]  rdy;
  logic [2:0]  sclk;
  logic [2:0]  lrck;
  logic [2:0]  dac;
  logic [2:0]  ur;
  logic [2:0]  lvl [3];
  logic [15:0] l0, r0, l2, r2;
  logic [23:0] l1, r1;

  int errors = 0;
  int checks = 0;
  vec_t tbl [6];

  pocket_i2s_tx dut0 (
    .audio_mclk(clk), .reset(rst[0]), .audio_l(l0), .audio_r(r0), .audio_valid(vld[0]),
    .audio_ready(rdy[0]), .audio_sclk(sclk[0]), .audio_lrck(lrck[0]), .audio_dac(dac[0]),
    .underrun(ur[0]), .fifo_level(lvl[0])
  );

  pocket_i2s_tx #(.SAMPLE_WIDTH(24), .SLOT_WIDTH(24), .FORMAT(FMT_LJ)) dut1 (
    .audio_mclk(clk), .reset(rst[1]), .audio_l(l1), .audio_r(r1), .audio_valid(vld[1]),
    .audio_ready(rdy[1]), .audio_sclk(sclk[1]), .audio_lrck(lrck[1]), .audio_dac(dac[1]),
    .underrun(ur[1]), .fifo_level(lvl[1])
  );

  pocket_i2s_tx #(.MCLK_DIV(8)) dut2 (
    .audio_mclk(clk), .reset(rst[2]), .audio_l(l2), .audio_r(r2), .audio_valid(vld[2]),
    .audio_ready(rdy[2]), .audio_sclk(sclk[2]), .audio_lrck(lrck[2]), .audio_dac(dac[2]),
    .underrun(ur[2]), .fifo_level(lvl[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Leaves the caller at the negedge inside cycle 0 (first cycle with reset low).
  task automatic do_reset(input logic [1:0] d);
    rst[d] = 1'b1;
    vld[d] = 1'b0;
    repeat (3) @(negedge clk);
    rst[d] = 1'b0;
  endtask

  task automatic chk_reset_vals(input logic [1:0] d, input string tag);
    chk({tag, "_sclk"},  64'(sclk[d]), 64'd0);
    chk({tag, "_lrck"},  64'(lrck[d]), 64'd0);
    chk({tag, "_dac"},   64'(dac[d]),  64'd0);
    chk({tag, "_ur"},    64'(ur[d]),   64'd0);
    chk({tag, "_level"}, 64'(lvl[d]),  64'd0);
    chk({tag, "_ready"}, 64'(rdy[d]),  64'd1);
  endtask

  // Called at the negedge of a frame-start cycle; returns at the next one.
  task automatic capture(input logic [1:0] d, input int m, input int nbits,
                         output logic [63:0] bits, output logic [63:0] lr);
    bits = '0;
    lr   = '0;
    repeat (m/2 + 1) @(negedge clk);
    for (int p = 0; p < nbits; p++) begin
      if (p > 0) repeat (m) @(negedge clk);
      bits = {bits[62:0], dac[d]};
      lr   = {lr[62:0], lrck[d]};
    end
    repeat (m/2 - 1) @(negedge clk);
  endtask

  initial begin
    logic [63:0] bits, lr;
    logic [3:0]  sc;
    int          ur_at [4];
    int          lr_at [3];
    int          ur_n, lr_n, rises;
    logic        dac_any, prev_l, prev_s;

    tbl[0] = '{16'h8001, 16'h7FFE, 64'h40008000_3FFF0000};
    tbl[1] = '{16'hFFFF, 16'h0000, 64'h7FFF8000_00000000};
    tbl[2] = '{16'h0000, 16'hFFFF, 64'h00000000_7FFF8000};
    tbl[3] = '{16'h1234, 16'hABCD, 64'h091A0000_55E68000};
    tbl[4] = '{16'h5555, 16'hAAAA, 64'h2AAA8000_55550000};
    tbl[5] = '{16'h0001, 16'h8000, 64'h00008000_40000000};

    rst = 3'b111; vld = 3'b000;
    l0 = '0; r0 = '0; l1 = '0; r1 = '0; l2 = '0; r2 = '0;

    // One pair then idle: I2S framing, then an underrun repeat.
    do_reset(2'd0);
    chk_reset_vals(2'd0, "rst0");
    l0 = 16'h8001; r0 = 16'h7FFE; vld[0] = 1'b1;
    sc = {3'b000, sclk[0]};
    @(negedge clk); vld[0] = 1'b0; sc = {sc[2:0], sclk[0]};
    chk("push_level", 64'(lvl[0]), 64'd1);
    @(negedge clk); sc = {sc[2:0], sclk[0]};
    @(negedge clk); sc = {sc[2:0], sclk[0]};
    chk("sclk_first4", 64'(sc), 64'b0011);
    chk("ur_frame0", 64'(ur[0]), 64'd0);
    capture(2'd0, 4, 64, bits, lr);
    chk("a_frame0_dac", bits, 64'h40008000_3FFF0000);
    chk("a_frame0_lrck", lr, 64'h00000000_FFFFFFFF);
    chk("ur_frame1", 64'(ur[0]), 64'd1);
    chk("a_level_empty", 64'(lvl[0]), 64'd0);
    capture(2'd0, 4, 64, bits, lr);
    chk("a_frame1_repeat", bits, 64'h40008000_3FFF0000);

    // No pushes: cadence of sclk, lrck and underrun over 600 cycles.
    do_reset(2'd0);
    ur_n = 0; lr_n = 0; rises = 0; dac_any = 1'b0; prev_l = 1'b0; prev_s = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (ur[0]) begin
        if (ur_n < 4) ur_at[ur_n] = c;
        ur_n++;
      end
      if (lrck[0] && !prev_l) begin
        if (lr_n < 3) lr_at[lr_n] = c;
        lr_n++;
      end
      if (sclk[0] && !prev_s) rises++;
      dac_any = dac_any | dac[0];
      prev_l = lrck[0];
      prev_s = sclk[0];
      @(negedge clk);
    end
    chk("idle_ur_count", 64'(ur_n), 64'd3);
    chk("idle_ur_first", 64'(ur_at[0]), 64'd3);
    chk("idle_ur_second", 64'(ur_at[1]), 64'd259);
    chk("idle_ur_third", 64'(ur_at[2]), 64'd515);
    chk("idle_lrck_rises", 64'(lr_n), 64'd2);
    chk("idle_lrck_first", 64'(lr_at[0]), 64'd132);
    chk("idle_lrck_second", 64'(lr_at[1]), 64'd388);
    chk("idle_sclk_rises", 64'(rises), 64'd150);
    chk("idle_dac_zero", 64'(dac_any), 64'd0);

    // Continuous valid: table frames in order, FIFO fills, one underrun when drained.
    do_reset(2'd0);
    fork
      begin : pusher
        int idx, mlev, lvl_bad;
        logic p_push, p_pop;
        idx = 0; mlev = 0; lvl_bad = 0;
        for (int c = 0; c < 300; c++) begin
          if (idx < 6) begin
            vld[0] = 1'b1; l0 = tbl[idx].l; r0 = tbl[idx].r;
          end else begin
            vld[0] = 1'b0;
          end
          if (lvl[0] !== 3'(mlev) || rdy[0] !== (mlev < 4)) lvl_bad++;
          if (c == 5) chk("fill_level4", 64'(lvl[0]), 64'd4);
          if (c == 259) chk("full_ready_low", 64'(rdy[0]), 64'd0);
          if (c == 260) chk("ready_after_pop", 64'(rdy[0]), 64'd1);
          p_push = (idx < 6) && (mlev < 4);
          p_pop  = ((c % 256) == 3) && (mlev > 0);
          mlev   = mlev + int'(p_push) - int'(p_pop);
          if (p_push) idx++;
          @(negedge clk);
        end
        vld[0] = 1'b0;
        chk("level_tracking", 64'(lvl_bad), 64'd0);
        chk("all_pushed", 64'(idx), 64'd6);
      end
      begin : player
        logic [63:0] fb, fl;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
          chk($sformatf("stream_ur_f%0d", k), 64'(ur[0]), 64'd0);
          capture(2'd0, 4, 64, fb, fl);
          chk($sformatf("stream_frame%0d", k), fb, tbl[k].i2s);
        end
        chk("stream_drained_ur", 64'(ur[0]), 64'd1);
      end
    join

    // LJ, 24-bit samples in 24-bit slots: no padding, MSB on the lrck edge.
    do_reset(2'd1);
    chk_reset_vals(2'd1, "rst1");
    l1 = 24'hABCDEF; r1 = 24'h5A5A5A; vld[1] = 1'b1;
    @(negedge clk); vld[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("lj_ur_frame0", 64'(ur[1]), 64'd0);
    capture(2'd1, 4, 48, bits, lr);
    chk("lj_frame0_dac", bits, 64'h0000ABCD_EF5A5A5A);
    chk("lj_frame0_lrck", lr, 64'h00000000_00FFFFFF);
    chk("lj_ur_frame1", 64'(ur[1]), 64'd1);
    chk("lj_c195", {lrck[1], dac[1]}, 64'b10);
    @(negedge clk);
    chk("lj_c196", {sclk[1], lrck[1], dac[1]}, 64'b001);
    repeat (95) @(negedge clk);
    chk("lj_c291", {lrck[1], dac[1]}, 64'b01);
    @(negedge clk);
    chk("lj_c292", {lrck[1], dac[1]}, 64'b10);

    // MCLK_DIV=8: push lands exactly on the frame-start cycle of an empty FIFO.
    do_reset(2'd2);
    repeat (7) @(negedge clk);
    l2 = 16'hC003; r2 = 16'h0180; vld[2] = 1'b1;
    chk("d8_ur_on_push", 64'(ur[2]), 64'd1);
    chk("d8_level_before", 64'(lvl[2]), 64'd0);
    fork
      begin
        @(negedge clk);
        vld[2] = 1'b0;
        chk("d8_level_after", 64'(lvl[2]), 64'd1);
      end
      capture(2'd2, 8, 64, bits, lr);
    join
    chk("d8_frame0_silent", bits, 64'd0);
    chk("d8_ur_frame1", 64'(ur[2]), 64'd0);
    capture(2'd2, 8, 64, bits, lr);
    chk("d8_frame1_dac", bits, 64'h60018000_00C00000);
    chk("d8_ur_frame2", 64'(ur[2]), 64'd1);

    // Reset mid-right-slot with three frames queued.
    do_reset(2'd0);
    l0 = 16'hFFFF; r0 = 16'hFFFF; vld[0] = 1'b1;
    repeat (4) @(negedge clk);
    vld[0] = 1'b0;
    chk("mid_queued", 64'(lvl[0]), 64'd3);
    repeat (162) @(negedge clk);
    chk("mid_right_slot", {lrck[0], dac[0]}, 64'b11);
    rst[0] = 1'b1;
    @(negedge clk);
    chk_reset_vals(2'd0, "midrst");
    rst[0] = 1'b0;
    l0 = tbl[3].l; r0 = tbl[3].r; vld[0] = 1'b1;
    @(negedge clk); vld[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("restart_ur", 64'(ur[0]), 64'd0);
    capture(2'd0, 4, 64, bits, lr);
    chk("restart_frame", bits, tbl[3].i2s);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
